// File: rtl/w5300_socket_cfg_seq.sv
// ---------------------------------------------------------------------------
// w5300_socket_cfg_seq
// Walks the socket-N register-configuration LUT and executes each entry on the
// W5300 register bus engine. LUT entry = {op, addr[9:0], data[15:0]}, where
// op=0 is a register write and op=1 is a Sn_SSR status poll. A poll is re-read
// every POLL_GAP cycles until the masked status matches SSR_EXPECT or POLL_MAX
// re-reads have failed. An entry with addr 10'h3FF terminates the table.
//
// Optional build macro: W5300_SEQ_ACK_TIMEOUT_EN
//   defined   - a bus_ack watchdog aborts a transaction after ACK_TIMEOUT
//               cycles in ISSUE and reports error
//   undefined - ISSUE waits for bus_ack indefinitely
// ---------------------------------------------------------------------------
module w5300_socket_cfg_seq #(
  parameter logic [15:0] SSR_EXPECT  = 16'h0022,
  parameter logic [15:0] SSR_MASK    = 16'h00FF,
  parameter logic [7:0]  POLL_MAX    = 8'd200,
  parameter logic [7:0]  POLL_GAP    = 8'd16
`ifdef W5300_SEQ_ACK_TIMEOUT_EN
  ,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1023
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  lut_index,
  input  logic [26:0] lut_data,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        bus_wr,
  output logic [9:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic [15:0] last_rdata
);

  localparam logic [9:0] END_ADDR = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, CHECK, GAP, ADVANCE, DONE, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  poll_cnt;
  logic [7:0]  gap_cnt;

  // LUT entry fields
  logic        lut_op;
  logic [9:0]  lut_addr;
  logic [15:0] lut_wdata;
  assign lut_op    = lut_data[26];
  assign lut_addr  = lut_data[25:16];
  assign lut_wdata = lut_data[15:0];

  logic ssr_match;
  logic gap_last;
  assign ssr_match = (last_rdata & SSR_MASK) == (SSR_EXPECT & SSR_MASK);
  // POLL_GAP of 0 still spends one cycle in GAP
  assign gap_last  = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, POLL_GAP};

`ifdef W5300_SEQ_ACK_TIMEOUT_EN
  logic [15:0] ack_cnt;
  logic        ack_timeout;
  assign ack_timeout = (ack_cnt == ACK_TIMEOUT - 16'd1);

  // Ack watchdog: counts cycles spent waiting in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ack_cnt <= '0;
    else if (state == ISSUE) ack_cnt <= ack_cnt + 16'd1;
    else                     ack_cnt <= '0;
  end
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = (lut_addr == END_ADDR) ? DONE : ISSUE;
      ISSUE: begin
        if (bus_ack)          state_nxt = bus_wr ? ADVANCE : CHECK;
`ifdef W5300_SEQ_ACK_TIMEOUT_EN
        else if (ack_timeout) state_nxt = ERR;
`endif
      end
      CHECK: begin
        if (ssr_match)              state_nxt = ADVANCE;
        else if (poll_cnt == POLL_MAX) state_nxt = ERR;
        else                        state_nxt = GAP;
      end
      GAP:     if (gap_last) state_nxt = ISSUE;
      ADVANCE: state_nxt = (lut_index == 6'h3F) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: req drops the cycle after ack or on reset
  always_comb begin
    bus_req = (state == ISSUE);
    busy    = (state == FETCH) || (state == ISSUE) || (state == CHECK) ||
              (state == GAP)   || (state == ADVANCE);
  end

  // Datapath registers: entry fields, counters, index and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      error      <= 1'b0;
      lut_index  <= '0;
      bus_wr     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      last_rdata <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          done      <= 1'b0;
          error     <= 1'b0;
          lut_index <= '0;
        end
        FETCH: if (lut_addr != END_ADDR) begin
          bus_wr    <= ~lut_op;
          bus_addr  <= lut_addr;
          bus_wdata <= lut_op ? 16'h0000 : lut_wdata;
          poll_cnt  <= '0;
        end
        ISSUE: if (bus_ack && !bus_wr) last_rdata <= bus_rdata;
        CHECK: if (!ssr_match && poll_cnt != POLL_MAX) begin
          poll_cnt <= poll_cnt + 8'd1;
          gap_cnt  <= '0;
        end
        GAP:     gap_cnt <= gap_cnt + 8'd1;
        ADVANCE: if (lut_index != 6'h3F) lut_index <= lut_index + 6'd1;
        DONE:    done  <= 1'b1;
        ERR:     error <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_socket_cfg_seq.sv
// ---------------------------------------------------------------------------
// Testbench for w5300_socket_cfg_seq. A bus responder acks 2 cycles after
// bus_req and logs every completed transaction; the socket-0 table is held in
// a vector array together with the bus transaction each entry must produce.
// ---------------------------------------------------------------------------
module tb_w5300_socket_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [5:0]  lut_index;
  logic [26:0] lut_data;
  logic        bus_req, bus_ack, bus_wr;
  logic [9:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata, last_rdata;

  always #5 clk = ~clk;

  w5300_socket_cfg_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .lut_index(lut_index), .lut_data(lut_data),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .last_rdata(last_rdata)
  );

  // LUT model
  logic [26:0] lut [64];
  assign lut_data = lut[lut_index];

  typedef struct {
    logic [26:0] entry;
    logic        has_txn;
    logic        exp_wr;
    logic [9:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;
  vec_t vecs [7];

  int n_checks = 0;
  int n_errors = 0;

  // Responder state / transaction log
  logic        ack_en;
  logic [15:0] rd_vals [4];
  int          rd_cnt;
  int          ncyc;
  int          last_ack_cyc;
  logic        prev_req;
  logic [26:0] txn_log [$];
  int          gap_log [$];
  logic        gap_rd  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder: ack 2 cycles after req, driven at negedge
  initial begin
    int wait_cnt;
    bus_ack = 1'b0; bus_rdata = '0; wait_cnt = 0; ncyc = 0;
    prev_req = 1'b0; last_ack_cyc = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        bus_ack = 1'b0; wait_cnt = 0;
      end else begin
        if (bus_req && !prev_req && txn_log.size() > 0) begin
          gap_log.push_back(ncyc - last_ack_cyc);
          gap_rd.push_back(!bus_wr);
        end
        if (bus_ack) begin
          bus_ack = 1'b0; wait_cnt = 0;
        end else if (bus_req && ack_en) begin
          wait_cnt++;
          if (wait_cnt == 2) begin
            bus_ack   = 1'b1;
            bus_rdata = bus_wr ? 16'h0000 : rd_vals[(rd_cnt > 3) ? 3 : rd_cnt];
            if (!bus_wr) rd_cnt++;
            txn_log.push_back({bus_wr, bus_addr, bus_wdata});
            last_ack_cyc = ncyc;
          end
        end else begin
          wait_cnt = 0;
        end
      end
      prev_req = bus_req;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    txn_log.delete(); gap_log.delete(); gap_rd.delete();
    rd_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    if (i == budget) begin
      n_checks++; n_errors++;
      $display("FAIL %s: no done/error within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  function automatic int count_reads();
    int n = 0;
    foreach (txn_log[k]) if (!txn_log[k][26]) n++;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; ack_en = 1'b1; rd_cnt = 0;
    rd_vals = '{16'h0022, 16'h0022, 16'h0022, 16'h0022};

    // Socket-0 table and the transaction each entry must produce
    vecs[0] = '{{1'b0, 10'h200, 16'h0002}, 1'b1, 1'b1, 10'h200, 16'h0002};
    vecs[1] = '{{1'b0, 10'h204, 16'h0140}, 1'b1, 1'b1, 10'h204, 16'h0140};
    vecs[2] = '{{1'b0, 10'h20A, 16'h1B58}, 1'b1, 1'b1, 10'h20A, 16'h1B58};
    vecs[3] = '{{1'b0, 10'h218, 16'h05C0}, 1'b1, 1'b1, 10'h218, 16'h05C0};
    vecs[4] = '{{1'b0, 10'h202, 16'h0001}, 1'b1, 1'b1, 10'h202, 16'h0001};
    vecs[5] = '{{1'b1, 10'h208, 16'h0022}, 1'b1, 1'b0, 10'h208, 16'h0000};
    vecs[6] = '{{1'b0, 10'h3FF, 16'h0000}, 1'b0, 1'b0, 10'h000, 16'h0000};
    foreach (lut[k]) lut[k] = {1'b0, 10'h3FF, 16'h0000};
    foreach (vecs[k]) lut[k] = vecs[k].entry;

    // Reset state
    #12;
    check("reset_outputs",
          {busy, done, error, lut_index, bus_req, bus_wr, bus_addr, bus_wdata, last_rdata},
          '0);

    // --- Test 1: socket-0 table, SSR matches first time ---
    do_reset();
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    wait_end("t1", 1000);
    check("t1_txn_count", txn_log.size(), 6);
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].has_txn && k < txn_log.size())
        check($sformatf("t1_txn%0d", k), txn_log[k],
              {vecs[k].exp_wr, vecs[k].exp_addr, vecs[k].exp_wdata});
    end
    for (int k = 0; k < 4 && k < gap_log.size(); k++)
      check($sformatf("t1_wr_spacing%0d", k), gap_log[k], 3);
    check("t1_flags", {done, error, busy}, 3'b100);
    check("t1_last_rdata", last_rdata, 16'h0022);

    // --- Test 2: three mismatching polls then 0xFF22 ---
    do_reset();
    rd_vals = '{16'h0000, 16'h0000, 16'h0000, 16'hFF22};
    pulse_start();
    wait_end("t2", 2000);
    check("t2_reads", count_reads(), 4);
    for (int k = 0; k < gap_log.size(); k++)
      if (gap_rd[k] && k >= 5)
        check($sformatf("t2_poll_gap%0d_ok", k), gap_log[k] >= 18, 1'b1);
    check("t2_flags", {done, error}, 2'b10);
    check("t2_last_rdata", last_rdata, 16'hFF22);

    // --- Test 3: status never matches ---
    do_reset();
    rd_vals = '{16'h0013, 16'h0013, 16'h0013, 16'h0013};
    pulse_start();
    wait_end("t3", 8000);
    check("t3_reads", count_reads(), 201);
    check("t3_flags", {done, error, busy}, 3'b010);
    check("t3_lut_index", lut_index, 6'd5);

    // --- Test 4: start during busy is ignored ---
    do_reset();
    rd_vals = '{16'h0022, 16'h0022, 16'h0022, 16'h0022};
    pulse_start();
    repeat (10) @(negedge clk);
    check("t4_busy_mid", busy, 1'b1);
    pulse_start();
    wait_end("t4", 1000);
    check("t4_txn_count", txn_log.size(), 6);
    check("t4_done", done, 1'b1);

    // --- Test 5: asynchronous reset while bus_req is high on entry 2 ---
    do_reset();
    pulse_start();
    begin
      int i;
      for (i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus_req && lut_index == 6'd2) break;
      end
      check("t5_reached_entry2", i < 200, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_outputs_in_reset",
          {busy, done, error, lut_index, bus_req, bus_wr, bus_addr, bus_wdata, last_rdata},
          '0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int req_seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus_req || busy) req_seen++;
      end
      check("t5_idle_after_release", req_seen, 0);
    end

    // --- Test 6: bus_ack never arrives on entry 0 ---
    do_reset();
    ack_en = 1'b0;
    pulse_start();
    begin
      int high = 0;
      @(negedge clk);
      while (bus_req && high < 1500) begin
        high++;
        @(negedge clk);
      end
`ifdef W5300_SEQ_ACK_TIMEOUT_EN
      check("t6_req_cycles", high, 1023);
      @(negedge clk);
      check("t6_flags", {done, error, busy}, 3'b010);
      check("t6_lut_index", lut_index, 6'd0);
`else
      check("t6_req_held", high, 1500);
      check("t6_still_busy", {bus_req, busy, error}, 3'b110);
`endif
    end
    ack_en = 1'b1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
